signed_num_entry: RTL and testbench

Keypad-side counterpart of the sign/magnitude display path. It accumulates decimal digit keys and a minus key into a magnitude plus sign, then converts the result to a 25-bit two's-complement operand. The operand goes to the calculator core over a valid/ready handshake. It also exports the in-progress magnitude and sign so the display can echo the entry as it is typed, including a lone "-".

---
 rtl/calc_pkg.sv | 25 ++
 rtl/dec_accum.sv | 22 ++
 rtl/signed_num_entry.sv | 170 +++++++++++++++++
 tb/tb_signed_num_entry.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants, key codes and FSM state encoding for the keypad number-entry path.
package calc_pkg;

  localparam int WIDTH = 25;
  localparam logic [WIDTH-1:0] MAX_MAG = WIDTH'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic [3:0] MAX_DIGITS = 4'd8;

  localparam logic [3:0] KEY_0     = 4'd0;
  localparam logic [3:0] KEY_9     = 4'd9;
  localparam logic [3:0] KEY_MINUS = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd11;
  localparam logic [3:0] KEY_ENTER = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_CONV  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_9;
  endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal shift-add accumulator: next = mag*10 + digit, with a range check against MAX_MAG.
module dec_accum
  import calc_pkg::*;
(
  input  logic [WIDTH-1:0] mag_i,
  input  logic [3:0]       digit_i,
  output logic [WIDTH-1:0] next_mag_o,
  output logic             range_fail_o
);

  logic [WIDTH+3:0] mag_ext;
  logic [WIDTH+3:0] next_wide;

  // Four guard bits hold mag*10+9 for any in-range magnitude.
  always_comb begin
    mag_ext      = {4'b0000, mag_i};
    next_wide    = (mag_ext << 3) + (mag_ext << 1) + {{WIDTH{1'b0}}, digit_i};
    next_mag_o   = next_wide[WIDTH-1:0];
    range_fail_o = next_wide > {4'b0000, MAX_MAG};
  end

endmodule

// File: rtl/signed_num_entry.sv
// Keypad entry FSM: accumulates digits and sign, commits a two's-complement operand over valid/ready.
//
// state   | meaning
// S_IDLE  | magnitude 0, no significant digits yet; leading zeros dropped
// S_ENTRY | at least one significant digit entered
// S_CONV  | one cycle: sign/magnitude to two's complement
// S_HOLD  | out_valid high, waiting for out_ready
module signed_num_entry
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_num,
  output logic             out_valid,
  output logic             busy,
  output logic [WIDTH-1:0] disp_abs,
  output logic             disp_neg,
  output logic             ovf,
  output logic [3:0]       digit_cnt
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_num_q, out_num_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] disp_abs_q, disp_abs_d;
  logic             disp_neg_q, disp_neg_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       digit_cnt_q, digit_cnt_d;

  logic [WIDTH-1:0] acc_next;
  logic             acc_fail;
  logic             key_take;

  dec_accum u_dec_accum (
    .mag_i        (disp_abs_q),
    .digit_i      (key_code),
    .next_mag_o   (acc_next),
    .range_fail_o (acc_fail)
  );

  always_comb begin
    state_d     = state_q;
    out_num_d   = out_num_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    disp_abs_d  = disp_abs_q;
    disp_neg_d  = disp_neg_q;
    ovf_d       = ovf_q;
    digit_cnt_d = digit_cnt_q;
    key_take    = key_valid && !busy_q;

    case (state_q)
      S_IDLE: begin
        if (key_take) begin
          if (is_digit(key_code)) begin
            if (key_code != KEY_0) begin
              disp_abs_d  = {{(WIDTH-4){1'b0}}, key_code};
              digit_cnt_d = 4'd1;
              state_d     = S_ENTRY;
            end
          end else begin
            case (key_code)
              KEY_MINUS: disp_neg_d = ~disp_neg_q;
              KEY_CLEAR: begin
                disp_neg_d = 1'b0;
                ovf_d      = 1'b0;
              end
              KEY_ENTER: begin
                state_d = S_CONV;
                busy_d  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      S_ENTRY: begin
        if (key_take) begin
          if (is_digit(key_code)) begin
            if (digit_cnt_q == MAX_DIGITS || acc_fail) begin
              ovf_d = 1'b1;
            end else begin
              disp_abs_d  = acc_next;
              digit_cnt_d = digit_cnt_q + 4'd1;
            end
          end else begin
            case (key_code)
              KEY_MINUS: disp_neg_d = ~disp_neg_q;
              KEY_CLEAR: begin
                disp_abs_d  = '0;
                digit_cnt_d = 4'd0;
                disp_neg_d  = 1'b0;
                ovf_d       = 1'b0;
                state_d     = S_IDLE;
              end
              KEY_ENTER: begin
                state_d = S_CONV;
                busy_d  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      S_CONV: begin
        // Negating a zero magnitude yields zero, so "-0" normalises on its own.
        out_num_d   = disp_neg_q ? (~disp_abs_q + ONE) : disp_abs_q;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end

      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          disp_abs_d  = '0;
          digit_cnt_d = 4'd0;
          disp_neg_d  = 1'b0;
          ovf_d       = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_num_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      disp_abs_q  <= '0;
      disp_neg_q  <= 1'b0;
      ovf_q       <= 1'b0;
      digit_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      out_num_q   <= out_num_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      disp_abs_q  <= disp_abs_d;
      disp_neg_q  <= disp_neg_d;
      ovf_q       <= ovf_d;
      digit_cnt_q <= digit_cnt_d;
    end
  end

  assign out_num   = out_num_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign disp_abs  = disp_abs_q;
  assign disp_neg  = disp_neg_q;
  assign ovf       = ovf_q;
  assign digit_cnt = digit_cnt_q;

endmodule

// File: tb/tb_signed_num_entry.sv
// Directed bench for signed_num_entry: entry, sign, overflow limits, handshake timing and async reset.
module tb_signed_num_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        out_ready;
  logic [24:0] out_num;
  logic        out_valid;
  logic        busy;
  logic [24:0] disp_abs;
  logic        disp_neg;
  logic        ovf;
  logic [3:0]  digit_cnt;

  int n_checks = 0;
  int n_errors = 0;

  signed_num_entry dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .out_ready (out_ready),
    .out_num   (out_num),
    .out_valid (out_valid),
    .busy      (busy),
    .disp_abs  (disp_abs),
    .disp_neg  (disp_neg),
    .ovf       (ovf),
    .digit_cnt (digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Key held for exactly one rising edge; returns on the falling edge after it.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd15;
  endtask

  task automatic press_seq(input int digits[$]);
    foreach (digits[i]) press(4'(digits[i]));
  endtask

  // ENTER with out_ready high: out_valid must be a single-cycle pulse one edge after ENTER.
  task automatic enter_commit(input string tag, input logic [31:0] exp_num);
    out_ready = 1'b1;
    press(4'd12);
    check({tag, "_conv_busy"}, {31'b0, busy}, 32'd1);
    check({tag, "_conv_valid"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_valid_hi"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_num"}, {7'b0, out_num}, exp_num);
    @(negedge clk);
    check({tag, "_valid_lo"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_busy_lo"}, {31'b0, busy}, 32'd0);
    check({tag, "_abs_clr"}, {7'b0, disp_abs}, 32'd0);
    check({tag, "_neg_clr"}, {31'b0, disp_neg}, 32'd0);
    check({tag, "_cnt_clr"}, {28'b0, digit_cnt}, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd15;
    out_ready = 1'b0;
    #12;
    check("rst_num", {7'b0, out_num}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_abs", {7'b0, disp_abs}, 32'd0);
    check("rst_neg", {31'b0, disp_neg}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_cnt", {28'b0, digit_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Leading zero and ignored codes leave IDLE untouched.
    press(4'd0);
    press(4'd13);
    check("lead0_cnt", {28'b0, digit_cnt}, 32'd0);
    check("lead0_abs", {7'b0, disp_abs}, 32'd0);

    press_seq('{1, 2, 3});
    check("p123_abs", {7'b0, disp_abs}, 32'd123);
    check("p123_cnt", {28'b0, digit_cnt}, 32'd3);
    enter_commit("p123", 32'h000007B);

    press(4'd10);
    check("neg_only_neg", {31'b0, disp_neg}, 32'd1);
    check("neg_only_abs", {7'b0, disp_abs}, 32'd0);
    press_seq('{4, 5});
    check("n45_abs", {7'b0, disp_abs}, 32'd45);
    enter_commit("n45", 32'h1FFFFD3);

    press_seq('{1, 6, 7, 7, 7, 2, 1, 5});
    check("max_abs", {7'b0, disp_abs}, 32'd16777215);
    check("max_cnt", {28'b0, digit_cnt}, 32'd8);
    check("max_ovf0", {31'b0, ovf}, 32'd0);
    press(4'd0);
    check("max_extra_abs", {7'b0, disp_abs}, 32'd16777215);
    check("max_extra_cnt", {28'b0, digit_cnt}, 32'd8);
    check("max_extra_ovf", {31'b0, ovf}, 32'd1);
    enter_commit("max", 32'h0FFFFFF);
    check("max_ovf_clr", {31'b0, ovf}, 32'd0);

    press_seq('{1, 6, 7, 7, 7, 2, 1, 6});
    check("over_abs", {7'b0, disp_abs}, 32'd1677721);
    check("over_cnt", {28'b0, digit_cnt}, 32'd7);
    check("over_ovf", {31'b0, ovf}, 32'd1);
    press(4'd10);
    press(4'd11);
    check("clr_abs", {7'b0, disp_abs}, 32'd0);
    check("clr_cnt", {28'b0, digit_cnt}, 32'd0);
    check("clr_neg", {31'b0, disp_neg}, 32'd0);
    check("clr_ovf", {31'b0, ovf}, 32'd0);

    press_seq('{10, 10, 7});
    check("mm7_neg", {31'b0, disp_neg}, 32'd0);
    enter_commit("mm7", 32'd7);
    press(4'd10);
    enter_commit("negzero", 32'd0);

    // Held output with keys arriving while busy: all must be ignored.
    press(4'd9);
    press(4'd12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = 4'(i + 1);
      @(negedge clk);
      key_valid = 1'b0;
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_busy", {31'b0, busy}, 32'd1);
      check("hold_num", {7'b0, out_num}, 32'd9);
      check("hold_abs", {7'b0, disp_abs}, 32'd9);
    end

    #2;
    rst_n = 1'b0;
    #1;
    check("arst_num", {7'b0, out_num}, 32'd0);
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_abs", {7'b0, disp_abs}, 32'd0);
    check("arst_cnt", {28'b0, digit_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    press(4'd5);
    check("post_rst_abs", {7'b0, disp_abs}, 32'd5);
    check("post_rst_cnt", {28'b0, digit_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
